public_private_mac: RTL and testbench

Parametrised successor to the two-coefficient public×private multiplier in the LWE encryption datapath. Holds one packed word of public-key coefficients `A`. Streams the full row of secret-key words `s` against it, and emits one partial-product polynomial per `s` word to the downstream sum/accumulate stage. Generalises lane counts and coefficient width, honours backpressure on `B`, tracks `s` index ordering, and optionally supports ternary secrets.

---
 rtl/public_private_mac_if.sv | 52 +++++
 rtl/public_private_mac.sv | 169 ++++++++++++++++
 tb/tb_public_private_mac.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/public_private_mac_if.sv
// rtl/public_private_mac_if.sv - A/s/B handshake bundle for public_private_mac; TERNARY_S_EN widens secret lanes to 2 bits
interface public_private_mac_if #(
  parameter int COEF_W  = 18,
  parameter int A_LANES = 2,
  parameter int S_LANES = 2,
  parameter int IDX_W   = 10
);
`ifdef TERNARY_S_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif
  localparam int B_LANES = A_LANES + S_LANES - 1;

  // Public-key word input
  logic                        A_valid;
  logic                        A_ready;
  logic [IDX_W-1:0]            A_idx;
  logic [A_LANES*COEF_W-1:0]   pk_A;

  // Secret-key word input
  logic                        s_valid;
  logic                        s_ready;
  logic [IDX_W-1:0]            s_idx;
  logic [S_LANES*SB-1:0]       sk_s;

  // Partial-product output
  logic                        B_valid;
  logic                        B_ready;
  logic [B_LANES*COEF_W-1:0]   B_out;
  logic [IDX_W:0]              idx_B;
  logic                        B_last;
  logic                        err;

  modport master (
    output A_valid, A_idx, pk_A,
    input  A_ready,
    output s_valid, s_idx, sk_s,
    input  s_ready,
    input  B_valid, B_out, idx_B, B_last, err,
    output B_ready
  );

  modport slave (
    input  A_valid, A_idx, pk_A,
    output A_ready,
    input  s_valid, s_idx, sk_s,
    output s_ready,
    output B_valid, B_out, idx_B, B_last, err,
    input  B_ready
  );
endinterface

// File: rtl/public_private_mac.sv
// rtl/public_private_mac.sv - public x private coefficient multiplier; TERNARY_S_EN enables {-1,0,+1} secrets
module public_private_mac #(
  parameter int COEF_W  = 18,
  parameter int A_LANES = 2,
  parameter int S_LANES = 2,
  parameter int DEPTH   = 784,
  parameter int IDX_W   = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  public_private_mac_if.slave bus
);
`ifdef TERNARY_S_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif
  localparam int                 B_LANES  = A_LANES + S_LANES - 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - S_LANES);
  localparam logic [IDX_W:0]     S_STEP   = (IDX_W+1)'(S_LANES);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [COEF_W-1:0]          r_a [A_LANES];
  logic [IDX_W-1:0]           r_a_idx;
  logic [IDX_W:0]             r_exp;

  logic                       r_b_valid;
  logic [B_LANES*COEF_W-1:0]  r_b_out;
  logic [IDX_W:0]             r_idx_b;
  logic                       r_b_last;
  logic                       r_err;

  logic                       w_a_ready;
  logic                       w_s_ready;
  logic                       w_a_hs;
  logic                       w_s_hs;
  logic                       w_s_last;
  logic                       w_idx_err;
  logic                       w_enc_err;
  logic [COEF_W-1:0]          w_lane [B_LANES];
  logic [B_LANES*COEF_W-1:0]  w_prod;

  // One A_i * s_j term; negative secrets contribute the two's-complement of A_i.
  function automatic logic [COEF_W-1:0] lane_term(input logic [COEF_W-1:0] a,
                                                  input logic [SB-1:0]     s);
`ifdef TERNARY_S_EN
    case (s)
      2'b01:   return a;
      2'b11:   return {COEF_W{1'b0}} - a;
      default: return {COEF_W{1'b0}};
    endcase
`else
    return s[0] ? a : {COEF_W{1'b0}};
`endif
  endfunction

  assign w_a_hs    = bus.A_valid & w_a_ready;
  assign w_s_hs    = bus.s_valid & w_s_ready;
  assign w_s_last  = (bus.s_idx == LAST_IDX);
  assign w_idx_err = ({1'b0, bus.s_idx} != r_exp);

  // Flag any reserved 2'b10 secret code on the incoming word.
  always_comb begin
    w_enc_err = 1'b0;
`ifdef TERNARY_S_EN
    for (int j = 0; j < S_LANES; j++) begin
      if (bus.sk_s[j*SB +: SB] == 2'b10) w_enc_err = 1'b1;
    end
`endif
  end

  // Convolve the held A lanes with the incoming s lanes, mod 2^COEF_W per lane.
  always_comb begin
    for (int k = 0; k < B_LANES; k++) begin
      w_lane[k] = '0;
      for (int i = 0; i < A_LANES; i++) begin
        for (int j = 0; j < S_LANES; j++) begin
          if (i + j == k) begin
            w_lane[k] = w_lane[k] + lane_term(r_a[i], bus.sk_s[j*SB +: SB]);
          end
        end
      end
    end
  end

  for (genvar k = 0; k < B_LANES; k++) begin : g_pack
    assign w_prod[k*COEF_W +: COEF_W] = w_lane[k];
  end

  // Next-state and ready decode; s is only accepted when the output slot frees up this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_s_ready   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_a_ready = ~rst_in;
        if (bus.A_valid && !rst_in) w_state_nxt = ST_HELD;
      end
      ST_HELD: begin
        w_s_ready = ~rst_in & (~r_b_valid | bus.B_ready);
        if (bus.s_valid && w_s_ready && w_s_last) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Capture the public-key word on acceptance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < A_LANES; i++) r_a[i] <= '0;
      r_a_idx <= '0;
    end else if (w_a_hs) begin
      for (int i = 0; i < A_LANES; i++) r_a[i] <= bus.pk_A[i*COEF_W +: COEF_W];
      r_a_idx <= bus.A_idx;
    end
  end

  // Expected s index: restarts at 0 per row, then follows whatever index actually arrived.
  always_ff @(posedge clk_in) begin
    if (rst_in)      r_exp <= '0;
    else if (w_a_hs) r_exp <= '0;
    else if (w_s_hs) r_exp <= {1'b0, bus.s_idx} + S_STEP;
  end

  // Output register: load on s acceptance, otherwise drop valid once consumed.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_b_valid <= 1'b0;
      r_b_out   <= '0;
      r_idx_b   <= '0;
      r_b_last  <= 1'b0;
    end else if (w_s_hs) begin
      r_b_valid <= 1'b1;
      r_b_out   <= w_prod;
      r_idx_b   <= {1'b0, r_a_idx} + {1'b0, bus.s_idx};
      r_b_last  <= w_s_last;
    end else if (bus.B_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  // Sticky error: out-of-order index or reserved secret code.
  always_ff @(posedge clk_in) begin
    if (rst_in)                              r_err <= 1'b0;
    else if (w_s_hs && (w_idx_err || w_enc_err)) r_err <= 1'b1;
  end

  assign bus.A_ready = w_a_ready;
  assign bus.s_ready = w_s_ready;
  assign bus.B_valid = r_b_valid;
  assign bus.B_out   = r_b_out;
  assign bus.idx_B   = r_idx_b;
  assign bus.B_last  = r_b_last;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_public_private_mac.sv
// tb/tb_public_private_mac.sv - bench for public_private_mac (vector table, directed sequences, random vs reference)
module tb_public_private_mac;
  localparam int CW  = 18;
  localparam int AL  = 2;
  localparam int SL  = 2;
  localparam int DEP = 8;
  localparam int IW  = 10;
  localparam int BL  = AL + SL - 1;
`ifdef TERNARY_S_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  public_private_mac_if #(.COEF_W(CW), .A_LANES(AL), .S_LANES(SL), .IDX_W(IW)) bus ();

  public_private_mac #(.COEF_W(CW), .A_LANES(AL), .S_LANES(SL), .DEPTH(DEP), .IDX_W(IW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [CW-1:0]    a0, a1;
    logic [IW-1:0]    aidx;
    logic [1:0]       c0, c1;
    logic [IW-1:0]    sidx;
    logic [BL*CW-1:0] prod;
    logic [IW:0]      idxb;
    logic             last;
  } vec_t;

  typedef struct {
    logic [BL*CW-1:0] prod;
    logic [IW:0]      idx;
    logic             last;
  } exp_t;

  vec_t vecs[$];
  exp_t q[$];

  // Reference-model state for the random phase
  bit            m_held;
  int            m_next;
  logic [CW-1:0] m_a0, m_a1, m_off_a0, m_off_a1;
  int            m_aidx, m_off_aidx;
  logic [1:0]    m_c0, m_c1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [1:0] c);
`ifdef TERNARY_S_EN
    case (c)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
`else
    return int'(c[0]);
`endif
  endfunction

  function automatic logic [SL*SB-1:0] build_s(input logic [1:0] c0, input logic [1:0] c1);
`ifdef TERNARY_S_EN
    return {c1, c0};
`else
    return {c1[0], c0[0]};
`endif
  endfunction

  function automatic logic [1:0] rand_code();
`ifdef TERNARY_S_EN
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
`else
    return 2'($urandom_range(0, 1));
`endif
  endfunction

  // Polynomial product of two short coefficient vectors, reduced mod 2^CW.
  function automatic logic [BL*CW-1:0] ref_prod(input logic [CW-1:0] a0, input logic [CW-1:0] a1,
                                                input int v0, input int v1);
    longint av[AL];
    longint sv[SL];
    longint acc[BL];
    logic [BL*CW-1:0] r;
    av[0] = longint'(a0); av[1] = longint'(a1);
    sv[0] = longint'(v0); sv[1] = longint'(v1);
    for (int k = 0; k < BL; k++) acc[k] = 0;
    for (int i = 0; i < AL; i++)
      for (int j = 0; j < SL; j++)
        acc[i+j] += av[i] * sv[j];
    for (int k = 0; k < BL; k++) r[k*CW +: CW] = acc[k][CW-1:0];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.A_valid = 1'b0;
    bus.s_valid = 1'b0;
    bus.B_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready_low", 64'(bus.A_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_ready", 64'(bus.A_ready), 64'(1));
    check("rst_s_ready", 64'(bus.s_ready), 64'(0));
    check("rst_b_valid", 64'(bus.B_valid), 64'(0));
    check("rst_b_out",   64'(bus.B_out),   64'(0));
    check("rst_idx_b",   64'(bus.idx_B),   64'(0));
    check("rst_b_last",  64'(bus.B_last),  64'(0));
    check("rst_err",     64'(bus.err),     64'(0));
    @(posedge clk); #1;
  endtask

  task automatic load_a(input logic [CW-1:0] a0, input logic [CW-1:0] a1, input logic [IW-1:0] idx);
    int t;
    bus.A_valid = 1'b1;
    bus.pk_A    = {a1, a0};
    bus.A_idx   = idx;
    t = 0;
    @(negedge clk);
    while (!bus.A_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("a_accept", 64'(bus.A_ready), 64'(1));
    @(posedge clk); #1;
    bus.A_valid = 1'b0;
  endtask

  task automatic send_s(input logic [IW-1:0] idx, input logic [1:0] c0, input logic [1:0] c1);
    int t;
    bus.s_valid = 1'b1;
    bus.s_idx   = idx;
    bus.sk_s    = build_s(c0, c1);
    t = 0;
    @(negedge clk);
    while (!bus.s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("s_accept", 64'(bus.s_ready), 64'(1));
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic rand_cycle(input bit allow);
    bit a_hs, s_hs, b_hs, bv;
    exp_t e;
    if (allow) begin
      if (!bus.A_valid) begin
        bus.A_valid = 1'($urandom_range(0, 1));
        m_off_a0    = CW'($urandom);
        m_off_a1    = CW'($urandom);
        m_off_aidx  = int'($urandom_range(0, 1023));
        bus.pk_A    = {m_off_a1, m_off_a0};
        bus.A_idx   = IW'(m_off_aidx);
      end
      if (!bus.s_valid && m_held && m_next <= DEP - SL) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        m_c0        = rand_code();
        m_c1        = rand_code();
        bus.s_idx   = IW'(m_next);
        bus.sk_s    = build_s(m_c0, m_c1);
      end
      bus.B_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.A_valid = 1'b0;
      bus.s_valid = 1'b0;
      bus.B_ready = 1'b1;
    end
    @(negedge clk);
    bv = (q.size() > 0);
    check("rnd_a_ready", 64'(bus.A_ready), 64'(!m_held));
    check("rnd_s_ready", 64'(bus.s_ready), 64'(m_held && (!bv || bus.B_ready)));
    check("rnd_b_valid", 64'(bus.B_valid), 64'(bv));
    check("rnd_err",     64'(bus.err),     64'(0));
    if (bv) begin
      check("rnd_b_out",  64'(bus.B_out),  64'(q[0].prod));
      check("rnd_idx_b",  64'(bus.idx_B),  64'(q[0].idx));
      check("rnd_b_last", 64'(bus.B_last), 64'(q[0].last));
    end
    a_hs = bus.A_valid && !m_held;
    s_hs = bus.s_valid && m_held && (!bv || bus.B_ready);
    b_hs = bv && bus.B_ready;
    if (b_hs) void'(q.pop_front());
    if (s_hs) begin
      e.prod = ref_prod(m_a0, m_a1, sval(m_c0), sval(m_c1));
      e.idx  = (IW+1)'(m_aidx + m_next);
      e.last = (m_next == DEP - SL);
      q.push_back(e);
      if (m_next == DEP - SL) m_held = 1'b0;
      m_next += SL;
    end
    if (a_hs) begin
      m_held = 1'b1;
      m_a0   = m_off_a0;
      m_a1   = m_off_a1;
      m_aidx = m_off_aidx;
      m_next = 0;
    end
    @(posedge clk); #1;
    if (s_hs) bus.s_valid = 1'b0;
    if (a_hs) bus.A_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nxt;
    bit  sh;
    logic [IW:0] got[$];

    bus.A_valid = 1'b0;
    bus.A_idx   = '0;
    bus.pk_A    = '0;
    bus.s_valid = 1'b0;
    bus.s_idx   = '0;
    bus.sk_s    = '0;
    bus.B_ready = 1'b1;

    vecs.push_back('{18'd5,       18'd3,       10'd0,    2'b01, 2'b01, 10'd0,
                     {18'd3, 18'd8, 18'd5},               11'd0,    1'b0});
    vecs.push_back('{18'h3FFFF,   18'd1,       10'd0,    2'b01, 2'b01, 10'd0,
                     {18'd1, 18'd0, 18'h3FFFF},           11'd0,    1'b0});
    vecs.push_back('{18'h12345,   18'h0ABCD,   10'd100,  2'b01, 2'b00, 10'd2,
                     {18'd0, 18'h0ABCD, 18'h12345},       11'd102,  1'b0});
    vecs.push_back('{18'd7,       18'h3FFFF,   10'd1023, 2'b00, 2'b01, 10'd6,
                     {18'h3FFFF, 18'd7, 18'd0},           11'd1029, 1'b1});
    vecs.push_back('{18'd9,       18'd4,       10'd500,  2'b00, 2'b00, 10'd4,
                     {18'd0, 18'd0, 18'd0},               11'd504,  1'b0});
`ifdef TERNARY_S_EN
    vecs.push_back('{18'd7,       18'd2,       10'd0,    2'b11, 2'b01, 10'd0,
                     {18'd2, 18'd5, 18'h3FFF9},           11'd0,    1'b0});
`endif

    do_reset();

    foreach (vecs[v]) begin
      do_reset();
      load_a(vecs[v].a0, vecs[v].a1, vecs[v].aidx);
      for (int ix = 0; ix < int'(vecs[v].sidx); ix += SL) send_s(IW'(ix), 2'b00, 2'b00);
      send_s(vecs[v].sidx, vecs[v].c0, vecs[v].c1);
      @(negedge clk);
      check("vec_b_valid", 64'(bus.B_valid), 64'(1));
      check("vec_b_out",   64'(bus.B_out),   64'(vecs[v].prod));
      check("vec_idx_b",   64'(bus.idx_B),   64'(vecs[v].idxb));
      check("vec_b_last",  64'(bus.B_last),  64'(vecs[v].last));
      check("vec_err",     64'(bus.err),     64'(0));
      @(posedge clk); #1;
    end

    // Full row back-to-back
    do_reset();
    load_a(18'd5, 18'd3, 10'd0);
    bus.B_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bus.s_valid = 1'b1;
      bus.s_idx   = IW'(2 * w);
      bus.sk_s    = build_s(2'b01, 2'b01);
      @(negedge clk);
      check("row_s_ready", 64'(bus.s_ready), 64'(1));
      check("row_a_ready", 64'(bus.A_ready), 64'(0));
      if (w > 0) begin
        check("row_b_valid", 64'(bus.B_valid), 64'(1));
        check("row_idx_b",   64'(bus.idx_B),   64'(2 * (w - 1)));
        check("row_b_last",  64'(bus.B_last),  64'(0));
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("row_last_valid", 64'(bus.B_valid), 64'(1));
    check("row_last_idx",   64'(bus.idx_B),   64'(6));
    check("row_last_flag",  64'(bus.B_last),  64'(1));
    check("row_last_out",   64'(bus.B_out),   64'({18'd3, 18'd8, 18'd5}));
    check("row_retire_a",   64'(bus.A_ready), 64'(1));
    check("row_err",        64'(bus.err),     64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("row_drained", 64'(bus.B_valid), 64'(0));
    @(posedge clk); #1;

    // Backpressure on the first product, then release
    do_reset();
    load_a(18'd5, 18'd3, 10'd10);
    send_s(10'd0, 2'b01, 2'b00);
    bus.B_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_idx   = 10'd2;
    bus.sk_s    = build_s(2'b01, 2'b00);
    repeat (3) begin
      @(negedge clk);
      check("bp_s_ready", 64'(bus.s_ready), 64'(0));
      check("bp_b_valid", 64'(bus.B_valid), 64'(1));
      check("bp_idx_b",   64'(bus.idx_B),   64'(10));
      check("bp_b_out",   64'(bus.B_out),   64'({18'd0, 18'd3, 18'd5}));
      @(posedge clk); #1;
    end
    bus.B_ready = 1'b1;
    nxt = 2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.B_valid && bus.B_ready) got.push_back(bus.idx_B);
      sh = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (sh) begin
        nxt += 2;
        if (nxt > DEP - SL) bus.s_valid = 1'b0;
        else                bus.s_idx   = IW'(nxt);
      end
    end
    check("bp_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", 64'(got[i]), 64'(10 + 2 * i));

    // Ordering error is sticky until reset
    do_reset();
    load_a(18'd1, 18'd1, 10'd0);
    send_s(10'd0, 2'b01, 2'b01);
    @(negedge clk);
    check("ord_err_before", 64'(bus.err), 64'(0));
    @(posedge clk); #1;
    send_s(10'd4, 2'b01, 2'b01);
    @(negedge clk);
    check("ord_err",     64'(bus.err),     64'(1));
    check("ord_b_valid", 64'(bus.B_valid), 64'(1));
    check("ord_idx_b",   64'(bus.idx_B),   64'(4));
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("ord_err_sticky", 64'(bus.err), 64'(1));
    end
    @(posedge clk); #1;
    do_reset();

`ifdef TERNARY_S_EN
    // Reserved secret code contributes zero and raises err
    load_a(18'd7, 18'd2, 10'd0);
    send_s(10'd0, 2'b10, 2'b01);
    @(negedge clk);
    check("enc_err",   64'(bus.err),   64'(1));
    check("enc_b_out", 64'(bus.B_out), 64'({18'd2, 18'd7, 18'd0}));
    @(posedge clk); #1;
    do_reset();
`endif

    // Randomized traffic against the reference model
    m_held = 1'b0;
    m_next = 0;
    q.delete();
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 4; c++) rand_cycle(1'b0);
    check("rnd_queue_empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
